// File: rtl/mavg_pkg.sv
// Shared widths and helpers for the boxcar moving-average filter.
package mavg_pkg;

    // Default depth, matching the filter's default parameterisation.
    localparam int DEF_LOG2_MAX_DEPTH = 6;
    localparam int MAX_DEPTH          = 2 ** DEF_LOG2_MAX_DEPTH;

    // Width of the window-select field able to encode 0..log2_max.
    function automatic int sel_w(input int log2_max);
        return $clog2(log2_max + 1);
    endfunction

    // Accumulator/sum width: N*(2**width-1) always fits.
    function automatic int out_w(input int width, input int log2_max);
        return width + log2_max;
    endfunction

    // Oversized window requests saturate at the buffer depth.
    function automatic int clamp_win(input int sel, input int log2_max);
        return (sel > log2_max) ? log2_max : sel;
    endfunction

endpackage

// File: rtl/sample_ring.sv
// Circular sample store: one write port, one combinational read port.
// A read of the address being written returns the old contents.
module sample_ring #(
    parameter int WIDTH      = 10,
    parameter int LOG2_DEPTH = 6
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [LOG2_DEPTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [LOG2_DEPTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [2**LOG2_DEPTH];

    // Storage write; contents are never reset, the owner masks stale data.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/moving_avg_filter.sv
// Boxcar filter with runtime power-of-two window: running accumulator
// over a circular buffer, registered sum/average outputs.
module moving_avg_filter
    import mavg_pkg::*;
#(
    parameter  int WIDTH          = 10,
    parameter  int LOG2_MAX_DEPTH = 6,
    localparam int SEL_W          = sel_w(LOG2_MAX_DEPTH),
    localparam int OUT_W          = out_w(WIDTH, LOG2_MAX_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEL_W-1:0] i_win_log2,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_in,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_sum,
    output logic [WIDTH-1:0] o_avg,
    output logic             o_full
);

    localparam int CNT_W = LOG2_MAX_DEPTH + 1;

    logic [SEL_W-1:0]          r_win;
    logic [OUT_W-1:0]          r_acc;
    logic [CNT_W-1:0]          r_count;
    logic [LOG2_MAX_DEPTH-1:0] r_wp;

    logic [SEL_W-1:0]          w_win_clamped;
    logic                      w_flush;
    logic                      w_accept;
    logic [CNT_W-1:0]          w_n;
    logic                      w_full;
    logic [LOG2_MAX_DEPTH-1:0] w_raddr;
    logic [WIDTH-1:0]          w_rdata;
    logic [OUT_W-1:0]          w_oldest;
    logic [OUT_W-1:0]          w_acc_nxt;
    logic [CNT_W-1:0]          w_cnt_nxt;
    logic [WIDTH-1:0]          w_avg_nxt;

    assign w_win_clamped = SEL_W'(clamp_win(int'(i_win_log2), LOG2_MAX_DEPTH));
    assign w_flush       = (w_win_clamped != r_win);
    assign w_accept      = i_valid && !w_flush;

    // Window length and the slot leaving the window. At full depth the
    // truncated N is 0, so the oldest slot is wp itself (read-before-write).
    assign w_n     = CNT_W'(1) << r_win;
    assign w_full  = (r_count == w_n);
    assign w_raddr = r_wp - w_n[LOG2_MAX_DEPTH-1:0];

    // Only subtract once the window is primed; earlier slots may be stale.
    assign w_oldest  = w_full ? OUT_W'(w_rdata) : '0;
    assign w_acc_nxt = r_acc + OUT_W'(i_in) - w_oldest;
    assign w_cnt_nxt = w_full ? r_count : r_count + CNT_W'(1);
    assign w_avg_nxt = WIDTH'(w_acc_nxt >> r_win);

    sample_ring #(
        .WIDTH      (WIDTH),
        .LOG2_DEPTH (LOG2_MAX_DEPTH)
    ) u_ring (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_wp),
        .i_wdata (i_in),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Window tracking, running sum, fill count and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win   <= SEL_W'(LOG2_MAX_DEPTH);
            r_acc   <= '0;
            r_count <= '0;
            r_wp    <= '0;
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_avg   <= '0;
            o_full  <= 1'b0;
        end else if (w_flush) begin
            // New window: restart the fill; wp and last outputs hold.
            r_win   <= w_win_clamped;
            r_acc   <= '0;
            r_count <= '0;
            o_valid <= 1'b0;
            o_full  <= 1'b0;
        end else if (i_valid) begin
            r_acc   <= w_acc_nxt;
            r_count <= w_cnt_nxt;
            r_wp    <= r_wp + 1'b1;
            o_valid <= 1'b1;
            o_sum   <= w_acc_nxt;
            o_avg   <= w_avg_nxt;
            o_full  <= (w_cnt_nxt == w_n);
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_avg_filter.sv
// Self-checking bench for moving_avg_filter: a history-queue model
// pushes expected outputs into a scoreboard as stimulus is driven.
module tb_moving_avg_filter;

    localparam int WIDTH = 10;
    localparam int LMAX  = 6;
    localparam int SEL_W = 3;
    localparam int OUT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [SEL_W-1:0] i_win_log2;
    logic             i_valid;
    logic [WIDTH-1:0] i_in;
    logic             o_valid;
    logic [OUT_W-1:0] o_sum;
    logic [WIDTH-1:0] o_avg;
    logic             o_full;

    moving_avg_filter #(.WIDTH(WIDTH), .LOG2_MAX_DEPTH(LMAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_win_log2 (i_win_log2),
        .i_valid    (i_valid),
        .i_in       (i_in),
        .o_valid    (o_valid),
        .o_sum      (o_sum),
        .o_avg      (o_avg),
        .o_full     (o_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int avg;
        bit full;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    int   m_win;
    int   m_sum;
    int   m_avg;
    bit   m_full;
    bit   exp_out;
    int   n_chk  = 0;
    int   n_fail = 0;

    // Drive one cycle of stimulus, advance the model, push expectation.
    task automatic drive(input bit v, input int x, input int w);
        int cw;
        int s;
        cw = (w > LMAX) ? LMAX : w;
        i_valid    = v;
        i_in       = WIDTH'(x);
        i_win_log2 = SEL_W'(w);
        exp_out    = 1'b0;
        if (cw != m_win) begin
            m_win  = cw;
            hist.delete();
            m_full = 1'b0;
        end else if (v) begin
            hist.push_back(x);
            if (hist.size() > (1 << m_win)) void'(hist.pop_front());
            s = 0;
            foreach (hist[i]) s += hist[i];
            m_sum  = s;
            m_avg  = s >> m_win;
            m_full = (hist.size() == (1 << m_win));
            sb.push_back('{m_sum, m_avg, m_full});
            exp_out = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        i_valid    = 1'b0;
        i_in       = '0;
        i_win_log2 = SEL_W'(LMAX);
        @(posedge clk);
        #1;
        reset = 1'b0;
        hist.delete();
        sb.delete();
        m_win = LMAX; m_sum = 0; m_avg = 0; m_full = 0; exp_out = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++;
        if (o_valid !== 1'b0 || o_sum !== '0 || o_avg !== '0 || o_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: valid=%0b sum=%0d avg=%0d full=%0b, want all 0",
                     o_valid, o_sum, o_avg, o_full);
        end
    endtask

    // Constant full-scale input at N=16: ramp then steady state.
    task automatic test_fill_steady();
        exp_t e;
        drive(1, 1023, 4);
        n_chk++;
        if (o_valid !== 1'b0 || o_sum !== OUT_W'(m_sum)) begin
            n_fail++;
            $display("FAIL fill_flush: valid=%0b sum=%0d, want 0 and %0d", o_valid, o_sum, m_sum);
        end
        for (int k = 1; k <= 20; k++) begin
            drive(1, 1023, 4);
            n_chk++;
            if (o_valid !== 1'b1 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL fill_valid k=%0d: valid=%0b queued=%0d", k, o_valid, sb.size());
            end else begin
                e = sb.pop_front();
                if (o_sum !== OUT_W'(e.sum) || o_avg !== WIDTH'(e.avg) || o_full !== e.full) begin
                    n_fail++;
                    $display("FAIL fill k=%0d: sum=%0d/%0d avg=%0d/%0d full=%0b/%0b",
                             k, o_sum, e.sum, o_avg, e.avg, o_full, e.full);
                end
            end
            n_chk++;
            if (o_sum !== OUT_W'(1023 * ((k > 16) ? 16 : k)) || o_full !== (k >= 16)) begin
                n_fail++;
                $display("FAIL fill_const k=%0d: sum=%0d full=%0b", k, o_sum, o_full);
            end
        end
        n_chk++;
        if (o_sum !== 16'd16368 || o_avg !== 10'd1023) begin
            n_fail++;
            $display("FAIL steady: sum=%0d avg=%0d, want 16368 1023", o_sum, o_avg);
        end
    endtask

    // Full-depth window: oldest slot equals write slot.
    task automatic test_max_window();
        exp_t e;
        drive(0, 0, 6);
        for (int k = 1; k <= 80; k++) begin
            drive(1, (k % 2 == 0) ? 1000 : 0, 6);
            n_chk++;
            if (o_valid !== 1'b1 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL max_valid k=%0d: valid=%0b", k, o_valid);
            end else begin
                e = sb.pop_front();
                if (o_sum !== OUT_W'(e.sum) || o_avg !== WIDTH'(e.avg) || o_full !== e.full) begin
                    n_fail++;
                    $display("FAIL max k=%0d: sum=%0d/%0d avg=%0d/%0d full=%0b/%0b",
                             k, o_sum, e.sum, o_avg, e.avg, o_full, e.full);
                end
            end
            if (k >= 64) begin
                n_chk++;
                if (o_sum !== 16'd32000 || o_avg !== 10'd500 || o_full !== 1'b1) begin
                    n_fail++;
                    $display("FAIL max_const k=%0d: sum=%0d avg=%0d, want 32000 500", k, o_sum, o_avg);
                end
            end
        end
    endtask

    // Single-tap window passes samples straight through.
    task automatic test_win1();
        int seq[3];
        seq = '{5, 900, 0};
        drive(0, 0, 0);
        foreach (seq[i]) begin
            drive(1, seq[i], 0);
            if (sb.size() > 0) void'(sb.pop_front());
            n_chk++;
            if (o_valid !== 1'b1 || o_sum !== OUT_W'(seq[i]) || o_avg !== WIDTH'(seq[i]) || o_full !== 1'b1) begin
                n_fail++;
                $display("FAIL win1 i=%0d: valid=%0b sum=%0d avg=%0d full=%0b, want %0d",
                         i, o_valid, o_sum, o_avg, o_full, seq[i]);
            end
        end
    endtask

    // Window change mid-stream: flush drops a sample, then refill.
    task automatic test_window_switch();
        drive(1, 100, 4);
        for (int k = 0; k < 20; k++) drive(1, 100, 4);
        sb.delete();
        drive(1, 100, 2);
        n_chk++;
        if (o_valid !== 1'b0 || o_sum !== 16'd1600 || o_full !== 1'b0) begin
            n_fail++;
            $display("FAIL switch_flush: valid=%0b sum=%0d full=%0b, want 0 1600 0", o_valid, o_sum, o_full);
        end
        for (int k = 1; k <= 4; k++) begin
            drive(1, 100, 2);
            if (sb.size() > 0) void'(sb.pop_front());
            n_chk++;
            if (o_valid !== 1'b1 || o_sum !== OUT_W'(100 * k) || o_full !== (k == 4)) begin
                n_fail++;
                $display("FAIL switch k=%0d: valid=%0b sum=%0d full=%0b, want %0d", k, o_valid, o_sum, o_full, 100 * k);
            end
        end
        n_chk++;
        if (o_avg !== 10'd100) begin
            n_fail++;
            $display("FAIL switch_avg: avg=%0d, want 100", o_avg);
        end
    endtask

    // Random gaps and data at N=8; idle cycles must hold outputs.
    task automatic test_random_gaps();
        exp_t e;
        bit v;
        drive(0, 0, 3);
        for (int k = 0; k < 200; k++) begin
            v = ($urandom_range(0, 2) != 0);
            drive(v, $urandom_range(0, 1023), 3);
            n_chk++;
            if (o_valid !== exp_out) begin
                n_fail++;
                $display("FAIL rand_valid k=%0d: valid=%0b want %0b", k, o_valid, exp_out);
            end else if (exp_out) begin
                e = sb.pop_front();
                if (o_sum !== OUT_W'(e.sum) || o_avg !== WIDTH'(e.avg) || o_full !== e.full) begin
                    n_fail++;
                    $display("FAIL rand k=%0d: sum=%0d/%0d avg=%0d/%0d full=%0b/%0b",
                             k, o_sum, e.sum, o_avg, e.avg, o_full, e.full);
                end
            end else if (o_sum !== OUT_W'(m_sum) || o_avg !== WIDTH'(m_avg) || o_full !== m_full) begin
                n_fail++;
                $display("FAIL rand_hold k=%0d: sum=%0d/%0d avg=%0d/%0d full=%0b/%0b",
                         k, o_sum, m_sum, o_avg, m_avg, o_full, m_full);
            end
        end
    endtask

    // Reset mid-fill discards history; oversize select clamps, no flush.
    task automatic test_reset_clamp();
        for (int k = 0; k < 5; k++) drive(1, 77, 6);
        do_reset();
        n_chk++;
        if (o_valid !== 1'b0 || o_sum !== '0 || o_avg !== '0 || o_full !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset: valid=%0b sum=%0d avg=%0d full=%0b, want all 0",
                     o_valid, o_sum, o_avg, o_full);
        end
        for (int k = 1; k <= 64; k++) begin
            drive(1, 10, 7);
            if (sb.size() > 0) void'(sb.pop_front());
            if (k == 1 || k == 63) begin
                n_chk++;
                if (o_valid !== 1'b1 || o_sum !== OUT_W'(10 * k) || o_full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clamp k=%0d: valid=%0b sum=%0d full=%0b, want %0d", k, o_valid, o_sum, o_full, 10 * k);
                end
            end
        end
        n_chk++;
        if (o_sum !== 16'd640 || o_avg !== 10'd10 || o_full !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_full: sum=%0d avg=%0d full=%0b, want 640 10 1", o_sum, o_avg, o_full);
        end
    endtask

    initial begin
        reset = 1'b0; i_valid = 1'b0; i_in = '0; i_win_log2 = '0;
        #2;
        test_reset();
        test_fill_steady();
        test_max_window();
        test_win1();
        test_window_switch();
        test_random_gaps();
        test_reset_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/moving_avg_filter.md
Name: moving_avg_filter

Overview:
Parametrised boxcar filter for the received-light sample stream: runtime-selectable power-of-two window, valid-qualified input, and sum or average outputs. Replaces the fixed 16-tap free-running summer.
- Keeps a running accumulator (add newest, subtract oldest) over a circular sample buffer, instead of an N-input adder tree.
- Sits between the ADC capture stage and the sync/threshold detector.

Parameters:
WIDTH, 10, input sample width (unsigned)
LOG2_MAX_DEPTH, 6, log2 of maximum window; buffer holds 2**LOG2_MAX_DEPTH samples
(derived) SEL_W = $clog2(LOG2_MAX_DEPTH+1); OUT_W = WIDTH+LOG2_MAX_DEPTH

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
i_win_log2  input  SEL_W  window select, N = 2**i_win_log2; values >LOG2_MAX_DEPTH clamp to LOG2_MAX_DEPTH
i_valid  input  1  i_in carries a new sample this cycle
i_in  input  WIDTH  unsigned sample
o_valid  output  1  one-cycle strobe: o_sum/o_avg updated
o_sum  output  OUT_W  sum of last min(count,N) accepted samples
o_avg  output  WIDTH  o_sum >> win_r (truncating)
o_full  output  1  window primed (count==N)

Behaviour:
Reset (clk edge with reset=1):
- acc, count, wp, o_valid, o_sum, o_avg, o_full all 0; win_r = LOG2_MAX_DEPTH.
- Buffer contents are not reset; count masks stale entries.
- Reset mid-stream discards all history; the next accepted sample starts a fresh fill.

Window register and flush:
- win_r holds the clamped i_win_log2 and is compared every cycle.
- A flush cycle occurs when clamp(i_win_log2) != win_r. In a flush cycle:
  - win_r <= new value; acc, count, o_full <= 0; o_valid <= 0.
  - Any i_valid sample that cycle is dropped.
  - wp, o_sum and o_avg hold.
- Consequence: the first cycle out of reset with i_win_log2 != LOG2_MAX_DEPTH is a flush cycle.

Accept cycle (i_valid=1, no flush):
- oldest = (count==N) ? buf[wp-N mod 2**LOG2_MAX_DEPTH] : 0.
- The buffer is read-before-write, so N == max depth reads buf[wp] before it is overwritten.
- Register updates:
  - acc <= acc + i_in - oldest.
  - buf[wp] <= i_in; wp <= wp+1, wrapping.
  - count <= min(count+1, N).
  - o_valid <= 1; o_sum <= new acc; o_avg <= new acc >> win_r.
  - o_full <= (new count == N).
- Latency: outputs reflect the sample presented on cycle t, registered at the end of t, visible on cycle t+1.

Idle cycle (i_valid=0, no flush):
- o_valid <= 0; all other state and outputs hold.

Throughput and widths:
- Throughput is 1 sample/cycle; back-to-back i_valid is allowed, with no backpressure.
- acc is OUT_W bits wide and never overflows: the maximum is N*(2**WIDTH-1) < 2**OUT_W.
- The subtraction never underflows: acc always equals the exact sum of the last count samples.

Pre-full behaviour:
- o_avg is still acc >> win_r, so it under-estimates while filling.
- Consumers must qualify o_avg with o_full.

Decomposition:
Package mavg_pkg:
- SEL_W/OUT_W width functions.
- clamp_win() function.
- MAX_DEPTH = 2**LOG2_MAX_DEPTH.

Sub-module sample_ring:
- Parametrised WIDTH x 2**LOG2_MAX_DEPTH register array.
- One write port plus one combinational read port, read-before-write, no reset.

The top level owns acc, count, wp, win_r, flush detection and the output registers.

Test Plan:
1. Reset, win_log2=4, continuous i_valid, i_in=1023 -> o_sum = 1023·k for k=1..16; o_full rises with the 16th strobe; then steady o_sum=16368, o_avg=1023.
2. win_log2=6 (N=max), alternating 0/1000 -> after 64 samples o_sum=32000 and o_avg=500 on every strobe (exercises the wp-N==wp read-before-write case).
3. win_log2=0 -> o_sum=o_avg=last sample; o_full=1 from the first strobe; sequence 5,900,0 -> 5,900,0.
4. Steady at win=4 with i_in=100, switch to win=2 -> one flush cycle with o_valid=0 and the sample dropped; then o_sum 100,200,300,400; o_full on the 4th; o_avg=100.
5. Random i_valid gaps and random samples, win=3 -> match a scoreboard sum of the last ≤8 accepted samples; outputs hold and o_valid=0 on idle cycles.
6. Reset asserted mid-fill, then win_log2=7 -> all outputs 0 the cycle after reset; 7 clamps to 6 with no flush; constant 10 gives o_sum=640 after 64 samples.
